// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the RX FIFO and its consumer.
// Receiver side: rxData/rxDone/rxErr. Consumer side: outData/outValid/outReady.
// master = environment (receiver + consumer), slave = the FIFO.
interface uart_rx_fifo_if;
    logic [7:0] rxData;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;

    modport master (
        output rxData, rxDone, rxErr, outReady,
        input  outData, outValid
    );

    modport slave (
        input  rxData, rxDone, rxErr, outReady,
        output outData, outValid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular receive FIFO behind the UART receiver with sticky error flags and level irq.
// Latency: push visible next cycle (no bypass); outData is a combinational read of the head entry.
// Backpressure: none toward the receiver -- a byte arriving while full with no pop is dropped (overrun).
// Ports: clk, nReset (sync, active-low), en (oversample tick, idle timer only), bus (rx byte in,
//        ready/valid byte out), count, overrun/frameErr/timeout (sticky), clearFlags, irq, errCount.
// Optional: define UART_RX_FIFO_ERRCNT_EN to build the saturating 8-bit error counter on errCount;
//           otherwise errCount is tied to zero.
module uart_rx_fifo #(
    parameter int Depth        = 8,
    parameter int Threshold    = 4,
    parameter int TimeoutTicks = 64
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     en,
    uart_rx_fifo_if.slave            bus,
    output logic [$clog2(Depth):0]   count,
    output logic                     overrun,
    output logic                     frameErr,
    output logic                     timeout,
    input  logic                     clearFlags,
    output logic                     irq,
    output logic [7:0]               errCount
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TimeoutTicks);

    localparam logic [CW-1:0] DEPTH_C  = CW'(Depth);
    localparam logic [CW-1:0] THRESH_C = CW'(Threshold);
    localparam logic [TW-1:0] RELOAD   = TW'(TimeoutTicks - 1);

    logic [7:0]    mem [Depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [TW-1:0] timer;

    logic push;
    logic pop;
    logic drop;
    logic tmo_evt;
    logic overrun_d;
    logic frame_d;
    logic timeout_d;

    assign count        = count_q;
    assign bus.outValid = (count_q != '0);
    // Gated so the output reads zero while empty, independent of stale array contents.
    assign bus.outData  = bus.outValid ? mem[rd_ptr] : 8'h00;

    assign pop  = bus.outValid && bus.outReady;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push = bus.rxDone && ((count_q != DEPTH_C) || pop);
    assign drop = bus.rxDone && !push;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Timer sits at zero once expired; each further en re-asserts the event.
    assign tmo_evt = en && !push && !pop && bus.outValid && (timer == '0);

    // Sticky flags: a set event in the same cycle overrides clearFlags.
    assign overrun_d = drop      || (overrun  && !clearFlags);
    assign frame_d   = bus.rxErr || (frameErr && !clearFlags);
    assign timeout_d = tmo_evt   || (timeout  && !clearFlags);

    // Storage has no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rxData;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            timer    <= RELOAD;
            overrun  <= 1'b0;
            frameErr <= 1'b0;
            timeout  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_d;

            if (push || pop || !bus.outValid) begin
                timer <= RELOAD;
            end else if (en && (timer != '0)) begin
                timer <= timer - TW'(1);
            end

            overrun  <= overrun_d;
            frameErr <= frame_d;
            timeout  <= timeout_d;
            // Built from next-state values so irq tracks the flags and count in the same cycle.
            irq      <= (count_d >= THRESH_C) || overrun_d || frame_d || timeout_d;
        end
    end

`ifdef UART_RX_FIFO_ERRCNT_EN
    logic [7:0] err_cnt;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    // A framing error and a dropped byte in one cycle count as two events.
    assign err_inc = {1'b0, bus.rxErr} + {1'b0, drop};
    assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

    always_ff @(posedge clk) begin
        if (!nReset) begin
            err_cnt <= 8'd0;
        end else if (clearFlags) begin
            err_cnt <= {6'b0, err_inc};
        end else if (err_sum[8]) begin
            err_cnt <= 8'hFF;
        end else begin
            err_cnt <= err_sum[7:0];
        end
    end

    assign errCount = err_cnt;
`else
    assign errCount = 8'd0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int THR   = 4;
    localparam int TICKS = 64;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nReset;
    logic          en;
    logic [CW-1:0] count;
    logic          overrun;
    logic          frameErr;
    logic          timeout;
    logic          clearFlags;
    logic          irq;
    logic [7:0]    errCount;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.Depth(DEPTH), .Threshold(THR), .TimeoutTicks(TICKS)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .en         (en),
        .bus        (bus.slave),
        .count      (count),
        .overrun    (overrun),
        .frameErr   (frameErr),
        .timeout    (timeout),
        .clearFlags (clearFlags),
        .irq        (irq),
        .errCount   (errCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored bytes, idle pulse counter, flags, error total.
    logic [7:0] mq[$];
    bit         m_ov, m_fe, m_to, m_irq;
    int         m_idle;
    int         m_ec;

    function automatic logic [7:0] m_head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    // Advance the model with the inputs currently applied, clock once, then idle the pulses.
    task automatic tick();
        int pre_n;
        bit p, pu, dr, tev;
        int inc;
        pre_n = mq.size();
        if (!nReset) begin
            mq.delete();
            m_ov = 0; m_fe = 0; m_to = 0; m_irq = 0; m_idle = 0; m_ec = 0;
        end else begin
            p   = (pre_n > 0) && bus.outReady;
            pu  = bus.rxDone && ((pre_n < DEPTH) || p);
            dr  = bus.rxDone && !pu;
            tev = 0;
            if (p)  void'(mq.pop_front());
            if (pu) mq.push_back(bus.rxData);
            if (pu || p || pre_n == 0) m_idle = 0;
            else if (en) begin
                m_idle++;
                if (m_idle >= TICKS) tev = 1;
            end
            m_ov = dr        || (m_ov && !clearFlags);
            m_fe = bus.rxErr || (m_fe && !clearFlags);
            m_to = tev       || (m_to && !clearFlags);
            inc  = int'(bus.rxErr) + int'(dr);
            if (clearFlags) m_ec = inc;
            else            m_ec = (m_ec + inc > 255) ? 255 : m_ec + inc;
            m_irq = (mq.size() >= THR) || m_ov || m_fe || m_to;
        end
        @(posedge clk);
        #1;
        bus.rxDone = 0; bus.rxErr = 0; bus.outReady = 0; en = 0; clearFlags = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rxDone = 1; bus.rxData = b;
        tick();
    endtask

    task automatic pop_one();
        bus.outReady = 1;
        tick();
    endtask

    task automatic do_reset();
        nReset = 0;
        tick();
        tick();
        nReset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (bus.outValid !== 1'b0 || bus.outData !== 8'h00) begin
            n_fail++; $display("FAIL reset_out got valid=%b data=%h exp valid=0 data=00", bus.outValid, bus.outData); end
        n_checks++; if ({overrun, frameErr, timeout, irq} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got ov/fe/to/irq=%b exp=0000", {overrun, frameErr, timeout, irq}); end
        n_checks++; if (errCount !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got=%0d exp=0", errCount); end
    endtask

    task automatic test_ordering();
        logic [7:0] exp3 [3];
        exp3[0] = 8'h55; exp3[1] = 8'hA3; exp3[2] = 8'h0F;
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(exp3[i]);
        n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL order_count got=%0d exp=3", count); end
        n_checks++; if (bus.outData !== 8'h55) begin n_fail++; $display("FAIL order_head got=%h exp=55", bus.outData); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL order_irq got=%b exp=0", irq); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.outValid !== 1'b1 || bus.outData !== exp3[i]) begin
                n_fail++; $display("FAIL order_pop%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.outValid, bus.outData, exp3[i]); end
            pop_one();
        end
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL order_empty got valid=%b exp=0", bus.outValid); end
    endtask

    task automatic test_threshold_overrun();
        logic [7:0] b [DEPTH];
        do_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            b[k-1] = 8'($urandom_range(0, 8'hED));
            push_byte(b[k-1]);
            n_checks++; if (irq !== (k >= THR)) begin n_fail++; $display("FAIL thr_irq push%0d got=%b exp=%b", k, irq, k >= THR); end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL thr_no_ov got=%b exp=0", overrun); end
        push_byte(8'hEE);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL thr_overrun got=%b exp=1", overrun); end
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL thr_count got=%0d exp=%0d", count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (bus.outData !== b[i]) begin n_fail++; $display("FAIL thr_drain%0d got=%h exp=%h", i, bus.outData, b[i]); end
            pop_one();
        end
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL thr_empty got valid=%b exp=0", bus.outValid); end
    endtask

    task automatic test_full_concurrency();
        logic [7:0] exp_seq [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        bus.rxDone = 1; bus.rxData = 8'h77; bus.outReady = 1;
        tick();
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL conc_count got=%0d exp=%0d", count, DEPTH); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL conc_overrun got=%b exp=0", overrun); end
        for (int i = 0; i < DEPTH - 1; i++) exp_seq[i] = 8'h11 + 8'(i);
        exp_seq[DEPTH-1] = 8'h77;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (bus.outData !== exp_seq[i]) begin n_fail++; $display("FAIL conc_drain%0d got=%h exp=%h", i, bus.outData, exp_seq[i]); end
            pop_one();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h30 + 8'(i));
            n_checks++; if (bus.outValid !== 1'b1 || bus.outData !== 8'h30 + 8'(i)) begin
                n_fail++; $display("FAIL wrap%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.outValid, bus.outData, 8'h30 + 8'(i)); end
            pop_one();
        end
        n_checks++; if (bus.outValid !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL wrap_empty got valid=%b count=%0d exp 0/0", bus.outValid, count); end
    endtask

    task automatic test_timeout();
        do_reset();
        push_byte(8'h5A);
        for (int k = 1; k <= TICKS; k++) begin
            en = 1;
            tick();
            n_checks++; if (timeout !== (k == TICKS)) begin
                n_fail++; $display("FAIL tmo_pulse%0d got=%b exp=%b", k, timeout, k == TICKS); end
            tick();
        end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tmo_irq got=%b exp=1", irq); end
        clearFlags = 1;
        tick();
        n_checks++; if (timeout !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear got timeout=%b irq=%b exp 0/0", timeout, irq); end
        n_checks++; if (count !== CW'(1) || bus.outData !== 8'h5A) begin
            n_fail++; $display("FAIL tmo_keep got count=%0d data=%h exp 1/5a", count, bus.outData); end
    endtask

    task automatic test_errors();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.rxErr = 1;
            tick();
        end
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        push_byte(8'hEE);
        n_checks++; if (frameErr !== 1'b1 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL err_flags got fe=%b ov=%b exp 1/1", frameErr, overrun); end
        n_checks++; if (errCount !== (ERRCNT ? 8'd4 : 8'd0)) begin
            n_fail++; $display("FAIL err_count got=%0d exp=%0d", errCount, ERRCNT ? 4 : 0); end
        // framing error together with a dropped byte
        bus.rxErr = 1; bus.rxDone = 1; bus.rxData = 8'hEF;
        tick();
        n_checks++; if (errCount !== (ERRCNT ? 8'd6 : 8'd0)) begin
            n_fail++; $display("FAIL err_double got=%0d exp=%0d", errCount, ERRCNT ? 6 : 0); end
        clearFlags = 1;
        tick();
        n_checks++; if ({overrun, frameErr, timeout} !== 3'b000 || errCount !== 8'd0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL err_clear got ov/fe/to=%b errcnt=%0d irq=%b exp 000/0/1", {overrun, frameErr, timeout}, errCount, irq); end
    endtask

    task automatic test_random();
        logic [CW+22-1:0] got, exp;
        for (int c = 0; c < 1500; c++) begin
            bus.rxDone   = ($urandom_range(0, 99) < 45);
            bus.rxData   = 8'($urandom);
            bus.rxErr    = ($urandom_range(0, 99) < 3);
            bus.outReady = ($urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 40 : 10));
            en           = ($urandom_range(0, 99) < 70);
            clearFlags   = ($urandom_range(0, 99) < 4);
            nReset       = ($urandom_range(0, 199) != 0);
            tick();
            nReset = 1;
            got = {count, bus.outValid, bus.outData, overrun, frameErr, timeout, irq, errCount};
            exp = {CW'(mq.size()), (mq.size() > 0), m_head(), m_ov, m_fe, m_to, m_irq,
                   ERRCNT ? 8'(m_ec) : 8'd0};
            n_checks++; if (got !== exp) begin
                n_fail++; $display("FAIL rand_cycle%0d got=%h exp=%h (count,valid,data,ov,fe,to,irq,errcnt)", c, got, exp); end
        end
    endtask

    initial begin
        nReset = 0; en = 0; clearFlags = 0;
        bus.rxData = 8'h00; bus.rxDone = 0; bus.rxErr = 0; bus.outReady = 0;
        test_reset();
        test_ordering();
        test_threshold_overrun();
        test_full_concurrency();
        test_wrap();
        test_timeout();
        test_errors();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
